// File: rtl/ps2_frame_rx.sv
// PS/2 keyboard frame receiver: synchronises and filters the PS/2 lines, deserialises
// 11-bit frames, checks parity/stop/timeout and strips F0 (break) and E0 (extended) prefixes.
module ps2_frame_rx #(
    parameter int unsigned FILTER_LEN = 4,
    parameter int unsigned TIMEOUT    = 50000
) (
    input  logic       clk,
    input  logic       rstin,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       WriteEn,
    output logic [7:0] Code_Key,
    output logic       Ext_Key,
    output logic       Frame_Err
);

    localparam int unsigned FiltW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int unsigned TmoW  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDecode
    } state_t;

    logic             clk_meta;
    logic             clk_sync;
    logic             dat_meta;
    logic             dat_sync;

    logic             clk_filt;
    logic             clk_filt_prev;
    logic [FiltW-1:0] clk_cnt;
    logic             dat_filt;
    logic [FiltW-1:0] dat_cnt;

    logic             fall;
    logic             parity_ok;

    state_t           state;
    logic [3:0]       bit_cnt;
    logic [TmoW-1:0]  tmo_cnt;
    logic [7:0]       shift_reg;
    logic             par_bit;
    logic             brk_flag;
    logic             ext_flag;

    // Two-flop synchronisers; idle PS/2 lines are high, so reset to 1.
    always_ff @(posedge clk or negedge rstin) begin
        if (!rstin) begin
            clk_meta <= 1'b1;
            clk_sync <= 1'b1;
            dat_meta <= 1'b1;
            dat_sync <= 1'b1;
        end else begin
            clk_meta <= ps2_clk;
            clk_sync <= clk_meta;
            dat_meta <= ps2_data;
            dat_sync <= dat_meta;
        end
    end

    // The filtered level flips on the FILTER_LEN-th consecutive differing sample.
    always_ff @(posedge clk or negedge rstin) begin
        if (!rstin) begin
            clk_filt <= 1'b1;
            clk_cnt  <= '0;
        end else if (clk_sync == clk_filt) begin
            clk_cnt <= '0;
        end else if (clk_cnt == FiltW'(FILTER_LEN - 1)) begin
            clk_filt <= clk_sync;
            clk_cnt  <= '0;
        end else begin
            clk_cnt <= clk_cnt + FiltW'(1);
        end
    end

    always_ff @(posedge clk or negedge rstin) begin
        if (!rstin) begin
            dat_filt <= 1'b1;
            dat_cnt  <= '0;
        end else if (dat_sync == dat_filt) begin
            dat_cnt <= '0;
        end else if (dat_cnt == FiltW'(FILTER_LEN - 1)) begin
            dat_filt <= dat_sync;
            dat_cnt  <= '0;
        end else begin
            dat_cnt <= dat_cnt + FiltW'(1);
        end
    end

    always_ff @(posedge clk or negedge rstin) begin
        if (!rstin) begin
            clk_filt_prev <= 1'b1;
        end else begin
            clk_filt_prev <= clk_filt;
        end
    end

    assign fall      = clk_filt_prev & ~clk_filt;
    assign parity_ok = ^{shift_reg, par_bit};

    // The frame is judged on the stop-bit edge so the registered strobes land in the
    // DECODE cycle itself, one cycle after that edge.
    always_ff @(posedge clk or negedge rstin) begin
        if (!rstin) begin
            state     <= StIdle;
            bit_cnt   <= '0;
            tmo_cnt   <= '0;
            shift_reg <= '0;
            par_bit   <= 1'b0;
            brk_flag  <= 1'b0;
            ext_flag  <= 1'b0;
            WriteEn   <= 1'b0;
            Frame_Err <= 1'b0;
            Code_Key  <= 8'h00;
            Ext_Key   <= 1'b0;
        end else begin
            WriteEn   <= 1'b0;
            Frame_Err <= 1'b0;
            case (state)
                StIdle: begin
                    if (fall && !dat_filt) begin
                        state   <= StShift;
                        bit_cnt <= '0;
                        tmo_cnt <= '0;
                    end
                end
                StShift: begin
                    if (fall) begin
                        tmo_cnt <= '0;
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt < 4'd8) begin
                            shift_reg <= {dat_filt, shift_reg[7:1]};
                        end else if (bit_cnt == 4'd8) begin
                            par_bit <= dat_filt;
                        end else begin
                            state <= StDecode;
                            if (!parity_ok || !dat_filt) begin
                                Frame_Err <= 1'b1;
                                brk_flag  <= 1'b0;
                                ext_flag  <= 1'b0;
                            end else if (shift_reg == 8'hF0) begin
                                brk_flag <= 1'b1;
                            end else if (shift_reg == 8'hE0) begin
                                ext_flag <= 1'b1;
                            end else if (brk_flag) begin
                                brk_flag <= 1'b0;
                                ext_flag <= 1'b0;
                            end else begin
                                Code_Key <= shift_reg;
                                Ext_Key  <= ext_flag;
                                WriteEn  <= 1'b1;
                                ext_flag <= 1'b0;
                            end
                        end
                    end else if (tmo_cnt == TmoW'(TIMEOUT - 2)) begin
                        // Registered strobe: firing at count TIMEOUT-2 puts Frame_Err
                        // exactly TIMEOUT cycles after the last edge.
                        Frame_Err <= 1'b1;
                        brk_flag  <= 1'b0;
                        ext_flag  <= 1'b0;
                        state     <= StIdle;
                    end else begin
                        tmo_cnt <= tmo_cnt + TmoW'(1);
                    end
                end
                StDecode: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Self-checking bench for ps2_frame_rx: directed scenarios plus a randomized frame stream
// checked against a frame-level model of the prefix/parity rules.
module tb_ps2_frame_rx;

    localparam int unsigned FL   = 4;
    localparam int unsigned TMO  = 200;
    localparam int unsigned HALF = 20;

    logic       clk;
    logic       rstin;
    logic       ps2_clk;
    logic       ps2_data;
    logic       WriteEn;
    logic [7:0] Code_Key;
    logic       Ext_Key;
    logic       Frame_Err;

    ps2_frame_rx #(
        .FILTER_LEN(FL),
        .TIMEOUT   (TMO)
    ) dut (
        .clk      (clk),
        .rstin    (rstin),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .WriteEn  (WriteEn),
        .Code_Key (Code_Key),
        .Ext_Key  (Ext_Key),
        .Frame_Err(Frame_Err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int last_fall = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] ev_code[$];
    logic       ev_ext[$];
    int         ev_cyc[$];
    int         err_cyc[$];
    logic       both_hi = 1'b0;
    logic       hold_bad = 1'b0;
    logic [7:0] prev_code = 8'h00;
    logic       prev_ext = 1'b0;

    always @(negedge clk) begin
        if (rstin) begin
            if (WriteEn) begin
                ev_code.push_back(Code_Key);
                ev_ext.push_back(Ext_Key);
                ev_cyc.push_back(cyc);
            end
            if (Frame_Err) err_cyc.push_back(cyc);
            if (WriteEn && Frame_Err) both_hi <= 1'b1;
            if (!WriteEn && (Code_Key !== prev_code || Ext_Key !== prev_ext)) hold_bad <= 1'b1;
        end
        prev_code <= Code_Key;
        prev_ext  <= Ext_Key;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        ev_code.delete();
        ev_ext.delete();
        ev_cyc.delete();
        err_cyc.delete();
    endtask

    // Bit 0 is the start bit; odd parity means data plus parity has an odd count of ones.
    function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic bad_par,
                                             input logic bad_stop);
        logic par;
        par = bad_par ? ^b : ~^b;
        return {~bad_stop, par, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            tick(HALF);
            ps2_clk   = 1'b0;
            last_fall = cyc;
            tick(HALF);
            ps2_clk = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
        send_bits(mk_frame(b, bad_par, bad_stop), 11);
        tick(HALF);
        ps2_data = 1'b1;
        tick(HALF * 2);
    endtask

    task automatic test_reset();
        rstin    = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        tick(3);
        @(negedge clk);
        tests++; if (WriteEn !== 1'b0) begin fails++; $display("FAIL reset_we: got %b want 0", WriteEn); end
        tests++; if (Frame_Err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", Frame_Err); end
        tests++; if (Ext_Key !== 1'b0) begin fails++; $display("FAIL reset_ext: got %b want 0", Ext_Key); end
        tests++; if (Code_Key !== 8'h00) begin fails++; $display("FAIL reset_code: got %h want 00", Code_Key); end
        tick(1);
        clear_log();
        rstin = 1'b1;
        tick(30);
        tests++; if (ev_code.size() + err_cyc.size() != 0) begin
            fails++; $display("FAIL reset_release: got %0d strobes want 0", ev_code.size() + err_cyc.size());
        end
    endtask

    task automatic test_make();
        clear_log();
        send_frame(8'h1C, 1'b0, 1'b0);
        tests++; if (ev_code.size() != 1) begin
            fails++; $display("FAIL make_count: got %0d want 1", ev_code.size());
        end else begin
            tests++; if (ev_code[0] !== 8'h1C) begin fails++; $display("FAIL make_code: got %h want 1c", ev_code[0]); end
            tests++; if (ev_ext[0] !== 1'b0) begin fails++; $display("FAIL make_ext: got %b want 0", ev_ext[0]); end
            tests++; if (ev_cyc[0] != last_fall + 3 + FL) begin
                fails++; $display("FAIL make_latency: got cycle %0d want %0d", ev_cyc[0], last_fall + 3 + FL);
            end
        end
        tests++; if (err_cyc.size() != 0) begin fails++; $display("FAIL make_err: got %0d want 0", err_cyc.size()); end
    endtask

    task automatic test_prefix();
        clear_log();
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0);
        tests++; if (ev_code.size() != 0) begin fails++; $display("FAIL break_count: got %0d want 0", ev_code.size()); end
        clear_log();
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'h75, 1'b0, 1'b0);
        tests++; if (ev_code.size() != 1) begin
            fails++; $display("FAIL ext_count: got %0d want 1", ev_code.size());
        end else begin
            tests++; if (ev_code[0] !== 8'h75) begin fails++; $display("FAIL ext_code: got %h want 75", ev_code[0]); end
            tests++; if (ev_ext[0] !== 1'b1) begin fails++; $display("FAIL ext_flag: got %b want 1", ev_ext[0]); end
        end
        clear_log();
        send_frame(8'h1C, 1'b0, 1'b0);
        tests++; if (ev_code.size() != 1) begin
            fails++; $display("FAIL ext_clear_count: got %0d want 1", ev_code.size());
        end else begin
            tests++; if (ev_code[0] !== 8'h1C) begin fails++; $display("FAIL ext_clear_code: got %h want 1c", ev_code[0]); end
            tests++; if (ev_ext[0] !== 1'b0) begin fails++; $display("FAIL ext_clear_flag: got %b want 0", ev_ext[0]); end
        end
    endtask

    task automatic test_parity();
        logic [7:0] r;
        r = 8'($urandom_range(1, 8'hDF));
        send_frame(r, 1'b0, 1'b0);
        clear_log();
        send_frame(8'h1C, 1'b1, 1'b0);
        tests++; if (err_cyc.size() != 1) begin
            fails++; $display("FAIL par_err_count: got %0d want 1", err_cyc.size());
        end else begin
            tests++; if (err_cyc[0] != last_fall + 3 + FL) begin
                fails++; $display("FAIL par_err_latency: got cycle %0d want %0d", err_cyc[0], last_fall + 3 + FL);
            end
        end
        tests++; if (ev_code.size() != 0) begin fails++; $display("FAIL par_we: got %0d want 0", ev_code.size()); end
        tests++; if (Code_Key !== r) begin fails++; $display("FAIL par_hold: got %h want %h", Code_Key, r); end
        clear_log();
        send_frame(8'h32, 1'b0, 1'b0);
        tests++; if (ev_code.size() != 1 || ev_code[0] !== 8'h32) begin
            fails++; $display("FAIL par_recover: got %0d events code %h want 1 event code 32",
                              ev_code.size(), Code_Key);
        end
    endtask

    task automatic test_timeout();
        int exp_cyc;
        clear_log();
        send_bits(mk_frame(8'h29, 1'b0, 1'b0), 5);
        exp_cyc = last_fall + 2 + FL + TMO;
        ps2_data = 1'b1;
        tick(TMO + 40);
        tests++; if (err_cyc.size() != 1) begin
            fails++; $display("FAIL tmo_count: got %0d want 1", err_cyc.size());
        end else begin
            tests++; if (err_cyc[0] != exp_cyc) begin
                fails++; $display("FAIL tmo_cycle: got %0d want %0d", err_cyc[0], exp_cyc);
            end
        end
        tests++; if (ev_code.size() != 0) begin fails++; $display("FAIL tmo_we: got %0d want 0", ev_code.size()); end
        clear_log();
        send_frame(8'h29, 1'b0, 1'b0);
        tests++; if (ev_code.size() != 1 || ev_code[0] !== 8'h29 || ev_ext[0] !== 1'b0) begin
            fails++; $display("FAIL tmo_recover: got %0d events code %h want 1 event code 29 ext 0",
                              ev_code.size(), Code_Key);
        end
        tests++; if (err_cyc.size() != 0) begin fails++; $display("FAIL tmo_recover_err: got %0d want 0", err_cyc.size()); end
    endtask

    task automatic test_glitch();
        clear_log();
        ps2_data = 1'b0;
        tick(20);
        for (int w = 1; w < FL; w++) begin
            ps2_clk = 1'b0;
            tick(w);
            ps2_clk = 1'b1;
            tick(15);
        end
        ps2_data = 1'b1;
        tick(20);
        tests++; if (ev_code.size() + err_cyc.size() != 0) begin
            fails++; $display("FAIL glitch_strobe: got %0d strobes want 0", ev_code.size() + err_cyc.size());
        end
        send_frame(8'h1C, 1'b0, 1'b0);
        tests++; if (ev_code.size() != 1 || err_cyc.size() != 0 || Code_Key !== 8'h1C) begin
            fails++; $display("FAIL glitch_frame: got %0d events %0d errors code %h want 1 0 1c",
                              ev_code.size(), err_cyc.size(), Code_Key);
        end
    endtask

    task automatic test_reset_mid();
        clear_log();
        send_bits(mk_frame(8'h33, 1'b0, 1'b0), 4);
        rstin = 1'b0;
        tick(3);
        @(negedge clk);
        tests++; if ({WriteEn, Frame_Err, Ext_Key, Code_Key} !== 11'd0) begin
            fails++; $display("FAIL midrst_outputs: got we %b err %b ext %b code %h want all 0",
                              WriteEn, Frame_Err, Ext_Key, Code_Key);
        end
        tick(1);
        ps2_data = 1'b1;
        rstin    = 1'b1;
        tick(TMO + 20);
        tests++; if (ev_code.size() + err_cyc.size() != 0) begin
            fails++; $display("FAIL midrst_strobe: got %0d strobes want 0", ev_code.size() + err_cyc.size());
        end
        send_frame(8'h5A, 1'b0, 1'b0);
        tests++; if (ev_code.size() != 1 || Code_Key !== 8'h5A || err_cyc.size() != 0) begin
            fails++; $display("FAIL midrst_frame: got %0d events code %h want 1 event code 5a",
                              ev_code.size(), Code_Key);
        end
    endtask

    task automatic test_random();
        logic [7:0] exp_code[$];
        logic       exp_ext[$];
        int         exp_err;
        logic       brk;
        logic       ext;
        logic [7:0] b;
        logic       bad_par;
        logic       bad_stop;
        int         sel;
        brk     = 1'b0;
        ext     = 1'b0;
        exp_err = 0;
        clear_log();
        for (int n = 0; n < 24; n++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 2) b = 8'hF0;
            else if (sel == 2) b = 8'hE0;
            else b = 8'($urandom_range(0, 255));
            bad_par  = ($urandom_range(0, 7) == 0);
            bad_stop = !bad_par && ($urandom_range(0, 11) == 0);
            if (bad_par || bad_stop) begin
                exp_err++;
                brk = 1'b0;
                ext = 1'b0;
            end else if (b == 8'hF0) begin
                brk = 1'b1;
            end else if (b == 8'hE0) begin
                ext = 1'b1;
            end else if (brk) begin
                brk = 1'b0;
                ext = 1'b0;
            end else begin
                exp_code.push_back(b);
                exp_ext.push_back(ext);
                ext = 1'b0;
            end
            send_frame(b, bad_par, bad_stop);
        end
        tests++; if (err_cyc.size() != exp_err) begin
            fails++; $display("FAIL rand_err_count: got %0d want %0d", err_cyc.size(), exp_err);
        end
        tests++; if (ev_code.size() != exp_code.size()) begin
            fails++; $display("FAIL rand_ev_count: got %0d want %0d", ev_code.size(), exp_code.size());
        end else begin
            for (int i = 0; i < exp_code.size(); i++) begin
                tests++; if (ev_code[i] !== exp_code[i] || ev_ext[i] !== exp_ext[i]) begin
                    fails++; $display("FAIL rand_event[%0d]: got code %h ext %b want code %h ext %b",
                                      i, ev_code[i], ev_ext[i], exp_code[i], exp_ext[i]);
                end
            end
        end
    endtask

    task automatic test_invariants();
        tests++; if (both_hi !== 1'b0) begin fails++; $display("FAIL strobe_overlap: got %b want 0", both_hi); end
        tests++; if (hold_bad !== 1'b0) begin fails++; $display("FAIL code_hold: got %b want 0", hold_bad); end
    endtask

    initial begin
        test_reset();
        test_make();
        test_prefix();
        test_parity();
        test_timeout();
        test_glitch();
        test_reset_mid();
        test_random();
        test_invariants();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ps2_frame_rx.md
# ps2_frame_rx

Receives raw PS/2 keyboard traffic (device-driven `ps2_clk` / `ps2_data`), deserialises 11-bit frames, validates them, and strips break/extended prefixes. Every valid key press is emitted as a single-cycle `WriteEn` strobe with its scan code on `Code_Key`. It sits directly upstream of the data memory's keyboard write port (`we_kb` / `data_kb`) and runs in the 50 MHz system clock domain.

## Interface

Parameters:
- `FILTER_LEN`, default 4: consecutive identical samples required before a synchronised PS/2 line level is accepted.
- `TIMEOUT`, default 50000: maximum clk cycles allowed between falling edges inside a frame (1 ms at 50 MHz).

Ports:
- `clk`  in  1: system clock (50 MHz).
- `rstin`  in  1: reset, asynchronous, active-low.
- `ps2_clk`  in  1: PS/2 clock from the keyboard, asynchronous.
- `ps2_data`  in  1: PS/2 data from the keyboard, asynchronous.
- `WriteEn`  out  1: one-cycle strobe; a new make code is valid on `Code_Key`.
- `Code_Key`  out  8: last make code; held until the next `WriteEn`.
- `Ext_Key`  out  1: the code on `Code_Key` was preceded by E0; updated with `Code_Key`.
- `Frame_Err`  out  1: one-cycle strobe on a parity, stop-bit or timeout error.

## Operation

- **Input conditioning:** each PS/2 line passes through a 2-FF synchroniser, then a filter.
  - The filtered level changes only after `FILTER_LEN` consecutive equal synchronised samples.
  - A falling edge is a filtered `ps2_clk` transition from 1 to 0.
- **FSM states:** IDLE, SHIFT, DECODE.
- **IDLE:**
  - On a falling edge with filtered data = 0 (start bit): go to SHIFT, bit counter = 0, timeout counter = 0.
  - On a falling edge with data = 1: ignore it and stay in IDLE.
- **SHIFT:**
  - On each falling edge, sample filtered data. Bits 0–7 shift into the data register LSB first. Bit 8 is parity. Bit 9 is stop.
  - The timeout counter increments every cycle and clears on each falling edge.
  - After the stop bit is sampled, go to DECODE.
  - If the timeout counter reaches `TIMEOUT`: pulse `Frame_Err`, clear the break and extended flags, go to IDLE.
- **DECODE** (one cycle; always returns to IDLE):
  - Parity check: odd parity over data + parity bit must hold, and stop must be 1. Otherwise pulse `Frame_Err`, clear both flags, emit nothing.
  - Byte = F0: set the break flag; emit nothing.
  - Byte = E0: set the extended flag; emit nothing.
  - Other byte with the break flag set: a release. Clear both flags; emit nothing.
  - Other byte with the break flag clear: load `Code_Key` = byte and `Ext_Key` = extended flag, pulse `WriteEn`, clear the extended flag.
- **Typematic repeats** (the same make code received again) are emitted each time.
- **Reset** (`rstin` low, at any time, including mid-frame):
  - FSM returns to IDLE; counters, flags and data register are cleared.
  - Filter and synchroniser outputs are set to 1.
  - `WriteEn`, `Frame_Err`, `Ext_Key` = 0; `Code_Key` = 8'h00.
  - No strobe occurs on reset release.

## Timing

- Input latency: a line change is visible as a filtered edge 2 + `FILTER_LEN` cycles after it settles on the pin.
- Stop-bit edge detected in cycle N: DECODE runs in cycle N+1, and `WriteEn` / `Frame_Err` is high during cycle N+1 only.
- `Code_Key` and `Ext_Key` change in the same cycle `WriteEn` rises.
- Timeout fires exactly `TIMEOUT` cycles after the last in-frame falling edge.
- `WriteEn` and `Frame_Err` are never high in the same cycle. Consecutive strobes are at least one full PS/2 frame apart.
- No back-pressure: the consumer must accept `WriteEn` in the cycle it is high.
- A falling edge that lands in the DECODE cycle cannot occur at legal PS/2 rates (minimum bit time is about 3000 cycles), so it need not be handled.

## Test plan

- **Make code:** frame 0x1C (start 0, data LSB first, parity 0, stop 1) at a 10 kHz PS/2 clock → exactly one `WriteEn` pulse, `Code_Key` = 0x1C, `Ext_Key` = 0, `Frame_Err` stays 0.
- **Break and extended prefixes:**
  - Frames F0, 1C → no `WriteEn`.
  - Then frames E0, 75 → one `WriteEn`, `Code_Key` = 0x75, `Ext_Key` = 1.
  - Then frame 1C → `Code_Key` = 0x1C, `Ext_Key` = 0.
- **Parity error:** frame 0x1C with parity bit = 1 → one `Frame_Err` pulse, no `WriteEn`, `Code_Key` keeps its previous value. A following correct 0x32 frame → `WriteEn`, `Code_Key` = 0x32.
- **Timeout:** 5 bits sent, then the clock stops → `Frame_Err` exactly `TIMEOUT` cycles after the 5th edge. A full 0x29 frame afterwards → decoded correctly.
- **Glitch rejection:** 1–(`FILTER_LEN` − 1) cycle low pulses on `ps2_clk` while idle → no state change and no strobes. A following valid 0x1C frame → decoded.
- **Reset mid-frame:** `rstin` low after 4 bits, then high → all outputs 0, no strobe. A next complete frame 0x5A → `WriteEn`, `Code_Key` = 0x5A.
